// File: rtl/tdm_frame_serializer_pkg.sv
// Shared definitions for the TDM frame serializer and the downstream 1-to-4 demux.
// Provides the serializer state type, the channel count, the select width and the
// select encoding that maps channels 0..3 onto demux outputs A..D.
package tdm_frame_serializer_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SEL_W  = 2;

  localparam logic [SEL_W-1:0] CH_A = 2'b00;
  localparam logic [SEL_W-1:0] CH_B = 2'b01;
  localparam logic [SEL_W-1:0] CH_C = 2'b10;
  localparam logic [SEL_W-1:0] CH_D = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/tdm_frame_serializer_bit_period_timer.sv
// Bit-period timer: counts CLK_DIV cycles per serial bit and produces a registered
// strobe on the last cycle of each bit period.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   clear       - a new frame starts on this edge: counter restarts at 0
//   enable      - frame continues across this edge: counter advances (wrapping)
//   wrap        - current cycle is the last of its bit period (combinational)
//   bit_strobe  - registered: the cycle being entered is the last of its bit period
// With neither clear nor enable the counter parks at 0 and the strobe drops.
module bit_period_timer #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic wrap,
  output logic bit_strobe
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_nxt;

  assign wrap = (div_cnt == DIV_LAST);

  always_comb begin
    div_nxt = '0;
    if (enable && !clear && !wrap) begin
      div_nxt = div_cnt + 1'b1;
    end
  end

  // The strobe is computed from the next count so it lines up with the
  // registered data/sel outputs of the serializer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt    <= '0;
      bit_strobe <= 1'b0;
    end else begin
      div_cnt    <= div_nxt;
      bit_strobe <= (clear || enable) && (div_nxt == DIV_LAST);
    end
  end

endmodule

// File: rtl/tdm_frame_serializer.sv
// TDM frame serializer: accepts four WIDTH-bit channel words via valid/ready and
// sends them MSB-first on one serial line, channel 0..3 in order, each bit held for
// CLK_DIV cycles, with the demux channel select driven in step.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   in_valid / in_ready - frame handshake (in_ready is a state decode, low in reset)
//   ch0_data..ch3_data  - channel words, sampled on the accept edge
//   abort               - synchronous abort of a frame being shifted
//   data, sel           - serial bit and channel select to the demux
//   out_valid           - data/sel carry frame content
//   bit_strobe          - last cycle of each bit period
//   frame_done          - one-cycle pulse after a completed frame
//   busy                - frame in progress (state decode)
module tdm_frame_serializer
  import tdm_frame_serializer_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ch0_data,
  input  logic [WIDTH-1:0] ch1_data,
  input  logic [WIDTH-1:0] ch2_data,
  input  logic [WIDTH-1:0] ch3_data,
  input  logic             abort,
  output logic             data,
  output logic [1:0]       sel,
  output logic             out_valid,
  output logic             bit_strobe,
  output logic             frame_done,
  output logic             busy
);

  localparam int unsigned BIT_W = $clog2(WIDTH);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  state_t             state, state_nxt;
  logic [SEL_W-1:0]   ch_cnt, ch_nxt;
  logic [BIT_W-1:0]   bit_cnt, bit_nxt, bit_idx;
  logic [WIDTH-1:0]   words [NUM_CH];
  logic [WIDTH-1:0]   src   [NUM_CH];
  logic               accept, run, load, wrap, last_bit, last_ch, frame_end;

  assign in_ready  = !rst && (state == IDLE);
  assign busy      = (state != IDLE);

  assign accept    = (state == IDLE) && in_valid && !abort;
  assign last_bit  = (bit_cnt == BIT_LAST);
  assign last_ch   = (ch_cnt == CH_D);
  assign frame_end = (state == SHIFT) && wrap && last_bit && last_ch;
  assign run       = (state == SHIFT) && !abort && !frame_end;
  assign load      = accept || run;

  bit_period_timer #(
    .CLK_DIV(CLK_DIV)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .clear      (accept),
    .enable     (run),
    .wrap       (wrap),
    .bit_strobe (bit_strobe)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (abort) state_nxt = IDLE;
               else if (frame_end) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bit_nxt = '0;
    ch_nxt  = '0;
    if (run) begin
      bit_nxt = bit_cnt;
      ch_nxt  = ch_cnt;
      if (wrap) begin
        bit_nxt = last_bit ? '0 : bit_cnt + 1'b1;
        if (last_bit) ch_nxt = ch_cnt + 1'b1;
      end
    end
  end

  // On the accept edge the words are not latched yet, so the first bit is
  // taken straight from the inputs.
  always_comb begin
    src[0] = accept ? ch0_data : words[0];
    src[1] = accept ? ch1_data : words[1];
    src[2] = accept ? ch2_data : words[2];
    src[3] = accept ? ch3_data : words[3];
  end

  assign bit_idx = BIT_LAST - bit_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ch_cnt     <= '0;
      bit_cnt    <= '0;
      data       <= 1'b0;
      sel        <= CH_A;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) words[i] <= '0;
    end else begin
      state      <= state_nxt;
      ch_cnt     <= ch_nxt;
      bit_cnt    <= bit_nxt;
      out_valid  <= load;
      sel        <= load ? ch_nxt : CH_A;
      data       <= load && src[ch_nxt][bit_idx];
      frame_done <= (state_nxt == DONE);
      if (accept) begin
        words[0] <= ch0_data;
        words[1] <= ch1_data;
        words[2] <= ch2_data;
        words[3] <= ch3_data;
      end
    end
  end

endmodule

// File: tb/tb_tdm_frame_serializer.sv
// Bench for tdm_frame_serializer: two instances (CLK_DIV=1 and CLK_DIV=4, WIDTH=8)
// checked every cycle against a frame-position reference model.
module tb_tdm_frame_serializer;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [1:0]   in_valid, abort, in_ready, data, out_valid, bit_strobe, frame_done, busy;
  logic [1:0]   sel [2];
  logic [W-1:0] chd [2][4];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    tdm_frame_serializer #(
      .WIDTH   (W),
      .CLK_DIV ((g == 0) ? 1 : 4)
    ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid[g]),
      .in_ready   (in_ready[g]),
      .ch0_data   (chd[g][0]),
      .ch1_data   (chd[g][1]),
      .ch2_data   (chd[g][2]),
      .ch3_data   (chd[g][3]),
      .abort      (abort[g]),
      .data       (data[g]),
      .sel        (sel[g]),
      .out_valid  (out_valid[g]),
      .bit_strobe (bit_strobe[g]),
      .frame_done (frame_done[g]),
      .busy       (busy[g])
    );
  end

  int checks   = 0;
  int failures = 0;

  // Reference model: a frame is a position counter 0..L, L = 4*W*div; positions
  // below L are shift cycles, position L is the done cycle.
  bit           act [2];
  int           pos [2];
  logic [W-1:0] mw  [2][4];
  int           cyc = 0;
  int           last_acc [2];
  bit           hold_gap [2];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int div_of(int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic int flen(int d);
    return 4 * W * div_of(d);
  endfunction

  // {out_valid, sel, data, bit_strobe, frame_done, busy, in_ready}
  function automatic logic [7:0] exp_vec(int d);
    int dv, ch, b;
    logic [W-1:0] w;
    if (!act[d]) return {7'b0, !rst};
    if (pos[d] == flen(d)) return 8'b0000_1_1_0;
    dv = div_of(d);
    ch = pos[d] / (W * dv);
    b  = (pos[d] / dv) % W;
    w  = mw[d][ch];
    return {1'b1, 2'(ch), w[W-1-b], ((pos[d] % dv) == dv - 1), 1'b0, 1'b1, 1'b0};
  endfunction

  function automatic logic [7:0] obs_vec(int d);
    return {out_valid[d], sel[d], data[d], bit_strobe[d], frame_done[d], busy[d], in_ready[d]};
  endfunction

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        act[d] = 0;
        pos[d] = 0;
      end else if (!act[d]) begin
        if (in_valid[d] && !abort[d]) begin
          act[d] = 1;
          pos[d] = 0;
          for (int i = 0; i < 4; i++) mw[d][i] = chd[d][i];
          if (hold_gap[d] && last_acc[d] >= 0)
            check_eq($sformatf("gap_d%0d", d), cyc - last_acc[d], flen(d) + 2);
          last_acc[d] = cyc;
        end
      end else if (pos[d] < flen(d)) begin
        if (abort[d]) act[d] = 0;
        else pos[d]++;
      end else begin
        act[d] = 0;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(negedge clk);
    cyc++;
    for (int d = 0; d < 2; d++)
      check_eq($sformatf("d%0d_cyc%0d", d, cyc), obs_vec(d), exp_vec(d));
  endtask

  task automatic rand_words(input int d);
    for (int i = 0; i < 4; i++) chd[d][i] = W'($urandom);
  endtask

  task automatic drain();
    for (int n = 0; n < 400 && (act[0] || act[1]); n++) tick();
  endtask

  // Sends one frame on DUT d; abort_pos >= 0 raises abort while the model shows that position.
  task automatic run_frame(input int d, input logic [W-1:0] w0, w1, w2, w3, input int abort_pos);
    int ov_n, st_n, d_n, ones;
    ov_n = 0; st_n = 0; d_n = 0;
    ones = $countones(w0) + $countones(w1) + $countones(w2) + $countones(w3);
    chd[d][0] = w0; chd[d][1] = w1; chd[d][2] = w2; chd[d][3] = w3;
    in_valid[d] = 1'b1;
    tick();
    in_valid[d] = 1'b0;
    for (int n = 0; n < 400 && act[d]; n++) begin
      rand_words(d);
      ov_n += int'(out_valid[d]);
      st_n += int'(bit_strobe[d]);
      d_n  += int'(data[d]);
      abort[d] = (act[d] && pos[d] == abort_pos);
      tick();
      abort[d] = 1'b0;
    end
    if (abort_pos < 0) begin
      check_eq($sformatf("ov_len_d%0d", d), ov_n, flen(d));
      check_eq($sformatf("strobes_d%0d", d), st_n, 4 * W);
      check_eq($sformatf("ones_d%0d", d), d_n, ones * div_of(d));
    end
    check_eq($sformatf("idle_after_d%0d", d), {30'b0, busy[d], in_ready[d]}, 32'b01);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = '0;
    abort = '0;
    for (int d = 0; d < 2; d++) begin
      last_acc[d] = -1;
      hold_gap[d] = 0;
      act[d] = 0;
      pos[d] = 0;
      for (int i = 0; i < 4; i++) chd[d][i] = '0;
    end
    #1;
    for (int d = 0; d < 2; d++) check_eq($sformatf("reset_d%0d", d), obs_vec(d), 8'h00);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Directed frames from the plan.
    run_frame(0, 8'hA5, 8'h3C, 8'hFF, 8'h01, -1);
    run_frame(1, 8'h80, 8'h00, 8'h00, 8'h00, -1);
    run_frame(1, 8'hA5, 8'h3C, 8'hFF, 8'h01, -1);

    // in_valid held with words changing every cycle.
    for (int d = 0; d < 2; d++) begin
      hold_gap[d] = 1;
      last_acc[d] = -1;
      in_valid[d] = 1'b1;
      for (int n = 0; n < 3 * (flen(d) + 2) + 1; n++) begin
        rand_words(d);
        tick();
      end
      in_valid[d] = 1'b0;
      hold_gap[d] = 0;
      drain();
    end

    // Abort at bit 3 of channel 1, then a complete frame.
    for (int d = 0; d < 2; d++) begin
      run_frame(d, W'($urandom), W'($urandom), W'($urandom), W'($urandom), W * div_of(d) + 3 * div_of(d));
      run_frame(d, W'($urandom), W'($urandom), W'($urandom), W'($urandom), -1);
    end

    // Asynchronous reset between edges while both are shifting.
    rand_words(0);
    rand_words(1);
    in_valid = 2'b11;
    tick();
    in_valid = 2'b00;
    for (int n = 0; n < 20; n++) tick();
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) check_eq($sformatf("async_rst_d%0d", d), obs_vec(d), 8'h00);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // abort together with in_valid in IDLE, then a retry.
    rand_words(0);
    rand_words(1);
    in_valid = 2'b11;
    abort = 2'b11;
    tick();
    abort = 2'b00;
    tick();
    in_valid = 2'b00;
    drain();

    // Random traffic on both instances.
    for (int n = 0; n < 1500; n++) begin
      for (int d = 0; d < 2; d++) begin
        in_valid[d] = ($urandom_range(0, 3) == 0);
        abort[d]    = ($urandom_range(0, 40) == 0);
        rand_words(d);
      end
      tick();
    end
    in_valid = 2'b00;
    abort = 2'b00;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tdm_frame_serializer.md
Name: tdm_frame_serializer

Overview:
Upstream stage of the 1-to-4 demultiplexer. Accepts four parallel WIDTH-bit channel words through a valid/ready handshake. Time-division serializes them MSB-first onto a single data line, driving the 2-bit channel select in step. data and sel connect directly to the demux data/sel inputs, so each word appears bit-serially on demux outputs A, B, C and D in turn.

Parameters:
WIDTH, 8, bits per channel word (>=2)
CLK_DIV, 4, clock cycles each serial bit is held (>=1)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  producer has a frame on ch0_data..ch3_data
in_ready  output  1  block can accept a frame
ch0_data  input  WIDTH  word for channel 0 (demux output A)
ch1_data  input  WIDTH  word for channel 1 (B)
ch2_data  input  WIDTH  word for channel 2 (C)
ch3_data  input  WIDTH  word for channel 3 (D)
abort  input  1  synchronous frame abort
data  output  1  serial bit to demux data input
sel  output  2  channel select to demux sel input
out_valid  output  1  data/sel carry frame content
bit_strobe  output  1  pulses on last cycle of each bit period, for downstream sampling
frame_done  output  1  one-cycle pulse after a completed frame
busy  output  1  frame in progress (state != IDLE)

Behaviour:
- All outputs are registered except in_ready and busy, which are state decodes. in_ready is forced to 0 while rst is high.
- Reset: state=IDLE; data=0, sel=2'b00, out_valid=0, bit_strobe=0, frame_done=0, busy=0. All counters and word registers are cleared. Reset mid-frame discards the frame with no frame_done.
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready at edge k, latch all four words, clear ch_cnt/bit_cnt/div_cnt, and go to SHIFT. The first bit is visible on data from cycle k+1.
- SHIFT:
  - out_valid=1, sel=ch_cnt, data=word[ch_cnt][WIDTH-1-bit_cnt].
  - div_cnt counts 0..CLK_DIV-1. bit_strobe=1 when div_cnt==CLK_DIV-1; with CLK_DIV=1, bit_strobe stays high throughout SHIFT.
  - At div wrap, bit_cnt increments. At bit_cnt wrap (WIDTH-1 -> 0), ch_cnt increments.
  - After the last bit period of channel 3, go to DONE.
  - Frame length is exactly 4*WIDTH*CLK_DIV cycles of out_valid. Channel order is fixed 0,1,2,3.
- DONE: frame_done=1 for one cycle; out_valid=0, data=0, sel=2'b00. Return to IDLE on the next cycle.
- Throughput: the next accept is possible no earlier than the cycle after DONE. The back-to-back frame period is 4*WIDTH*CLK_DIV+2 cycles.
- in_valid during SHIFT/DONE is ignored and nothing is latched. The producer must hold its words until accepted.
- abort:
  - In SHIFT, abort forces IDLE on the next edge. out_valid, bit_strobe and data drop to 0, sel=00, and no frame_done pulse is issued.
  - In IDLE, abort and in_valid in the same cycle: abort wins and the frame is not accepted (in_ready is still shown as 1, but no transfer occurs).
  - In DONE, abort is ignored and frame_done still pulses.
- Outside SHIFT: data=0 and sel=00, so the demux drives all outputs low.

Decomposition:
- Shared package:
  - state enum {IDLE, SHIFT, DONE}
  - NUM_CH=4
  - SEL_W=2
  - sel encoding constants CH_A=2'b00 .. CH_D=2'b11, which the demux stage also uses
- One sub-module: bit_period_timer (div_cnt and bit_strobe generation, parameter CLK_DIV, enable and clear inputs). All other logic lives in tdm_frame_serializer.

Test Plan:
- WIDTH=8, CLK_DIV=1; ch0..ch3 = 8'hA5, 8'h3C, 8'hFF, 8'h01; pulse in_valid:
  - data stream is 10100101 00111100 11111111 00000001
  - sel is 00 x8, 01 x8, 10 x8, 11 x8
  - out_valid is high 32 cycles, followed by a frame_done pulse
- CLK_DIV=4, ch0=8'h80, others 0: data=1 for exactly 4 cycles, then 0 for 124 cycles; bit_strobe pulses every 4th cycle (32 pulses).
- in_valid held high continuously with changing words: only the words present at the accept edge are sent; accepts are spaced exactly 4*8*CLK_DIV+2 cycles apart.
- abort asserted at bit 3 of channel 1:
  - out_valid, data and sel go to 0/00 on the next cycle; no frame_done
  - in_ready=1 the cycle after
  - a new frame is then sent completely
- rst asserted mid-SHIFT (async, between edges):
  - all outputs 0 immediately, in_ready=0 during reset
  - after release, state is IDLE and in_ready=1
- Same cycle abort=1 and in_valid=1 in IDLE: no transfer, busy stays 0; a retry without abort is accepted.
